div: RTL and testbench

Multi-cycle integer divider controller for the HI/LO datapath. Accepts a DIV/DIVU request from the EX stage, latches the operands and runs a one-bit-per-cycle restoring division under a small state machine. It then holds a 64-bit {remainder, quotient} result for EX to forward down the whilo/hi/lo path through MEM to the HI/LO register file. EX stalls the pipeline while `ready_o` is low.

---
 rtl/div_pkg.sv | 29 ++
 rtl/div_step.sv | 31 +++
 rtl/div.sv | 138 +++++++++++++
 tb/tb_div.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg - shared definitions for the multi-cycle HI/LO divider.
//   Bus widths, reset/ready/start encodings, the divider state type and a
//   small helper that turns a (possibly signed) operand into its magnitude.
//   No ports (package).
package div_pkg;

    localparam int RegBus       = 32;
    localparam int DoubleRegBus = 64;

    localparam logic RstEnable         = 1'b1;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    // Two's-complement magnitude when the operand is treated as signed and negative.
    function automatic logic [RegBus-1:0] div_mag(input logic [RegBus-1:0] v,
                                                 input logic              is_signed);
        return (is_signed && v[RegBus-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step - one restoring-division iteration (purely combinational).
//   i_dividend [64:0] : working register; partial remainder in the upper half,
//                       remaining dividend bits / quotient bits in [31:0]
//   i_divisor  [31:0] : divisor magnitude
//   o_dividend [64:0] : working register after one subtract/shift step
module div_step
    import div_pkg::*;
(
    input  logic [DoubleRegBus:0] i_dividend,
    input  logic [RegBus-1:0]     i_divisor,
    output logic [DoubleRegBus:0] o_dividend
);

    logic [RegBus:0] w_diff;
    logic            w_unused;

    // Bit 64 never carries information: the partial remainder is always
    // smaller than the divisor, so the shift never pushes a one into it.
    assign w_unused = i_dividend[DoubleRegBus];

    always_comb begin
        // Shifted partial remainder (with next dividend bit) minus divisor.
        w_diff = i_dividend[DoubleRegBus-1:RegBus-1] - {1'b0, i_divisor};
        if (w_diff[RegBus]) begin
            o_dividend = {i_dividend[DoubleRegBus-1:0], 1'b0};
        end else begin
            o_dividend = {1'b0, w_diff[RegBus-1:0], i_dividend[RegBus-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div.sv
// div - multi-cycle DIV/DIVU controller for the HI/LO datapath.
//   clk          : pipeline clock
//   rst          : synchronous active-high reset
//   signed_div_i : 1 = DIV (signed), 0 = DIVU
//   opdata1_i    : dividend, sampled on request acceptance
//   opdata2_i    : divisor, sampled on request acceptance
//   start_i      : request, held by EX until the result is consumed
//   annul_i      : cancel an in-flight division
//   result_o     : {remainder -> HI, quotient -> LO}, registered
//   ready_o      : result valid, registered
module div
    import div_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    signed_div_i,
    input  logic [RegBus-1:0]       opdata1_i,
    input  logic [RegBus-1:0]       opdata2_i,
    input  logic                    start_i,
    input  logic                    annul_i,
    output logic [DoubleRegBus-1:0] result_o,
    output logic                    ready_o
);

    div_state_e              r_state;
    logic [5:0]              r_cnt;
    logic [DoubleRegBus:0]   r_dividend;
    logic [RegBus-1:0]       r_divisor;
    logic                    r_neg_q;
    logic                    r_neg_r;

    div_state_e              w_state_nxt;
    logic [5:0]              w_cnt_nxt;
    logic [DoubleRegBus:0]   w_dividend_nxt;
    logic [RegBus-1:0]       w_divisor_nxt;
    logic                    w_neg_q_nxt;
    logic                    w_neg_r_nxt;
    logic [DoubleRegBus-1:0] w_result_nxt;
    logic                    w_ready_nxt;

    logic [DoubleRegBus:0]   w_step;
    logic [RegBus-1:0]       w_quot;
    logic [RegBus-1:0]       w_rem;

    div_step u_step (
        .i_dividend (r_dividend),
        .i_divisor  (r_divisor),
        .o_dividend (w_step)
    );

    // After the final step the quotient sits in [31:0] and the remainder
    // directly above it in [63:32].
    assign w_quot = r_neg_q ? -w_step[RegBus-1:0]        : w_step[RegBus-1:0];
    assign w_rem  = r_neg_r ? -w_step[DoubleRegBus-1:RegBus] : w_step[DoubleRegBus-1:RegBus];

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_dividend_nxt = r_dividend;
        w_divisor_nxt  = r_divisor;
        w_neg_q_nxt    = r_neg_q;
        w_neg_r_nxt    = r_neg_r;
        w_result_nxt   = result_o;
        w_ready_nxt    = ready_o;

        case (r_state)
            DivFree: begin
                w_ready_nxt  = DivResultNotReady;
                w_result_nxt = '0;
                if (start_i == DivStart && !annul_i) begin
                    if (opdata2_i == '0) begin
                        w_state_nxt = DivByZero;
                    end else begin
                        w_state_nxt    = DivOn;
                        w_cnt_nxt      = '0;
                        w_divisor_nxt  = div_mag(opdata2_i, signed_div_i);
                        w_dividend_nxt = {33'b0, div_mag(opdata1_i, signed_div_i)};
                        w_neg_q_nxt    = signed_div_i & (opdata1_i[RegBus-1] ^ opdata2_i[RegBus-1]);
                        w_neg_r_nxt    = signed_div_i & opdata1_i[RegBus-1];
                    end
                end
            end
            DivByZero: begin
                w_state_nxt  = DivEnd;
                w_result_nxt = '0;
                w_ready_nxt  = DivResultReady;
            end
            DivOn: begin
                if (annul_i) begin
                    w_state_nxt  = DivFree;
                    w_ready_nxt  = DivResultNotReady;
                    w_result_nxt = '0;
                end else begin
                    w_dividend_nxt = w_step;
                    w_cnt_nxt      = r_cnt + 6'd1;
                    if (r_cnt == 6'd31) begin
                        w_state_nxt  = DivEnd;
                        w_ready_nxt  = DivResultReady;
                        w_result_nxt = {w_rem, w_quot};
                    end
                end
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    w_state_nxt  = DivFree;
                    w_ready_nxt  = DivResultNotReady;
                    w_result_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = DivFree;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_state    <= DivFree;
            r_cnt      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            result_o   <= '0;
            ready_o    <= DivResultNotReady;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_dividend <= w_dividend_nxt;
            r_divisor  <= w_divisor_nxt;
            r_neg_q    <= w_neg_q_nxt;
            r_neg_r    <= w_neg_r_nxt;
            result_o   <= w_result_nxt;
            ready_o    <= w_ready_nxt;
        end
    end

endmodule

// File: tb/tb_div.sv
// tb_div - self-checking bench for div: behavioural latency/result model
// plus directed and randomized divisions.
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 0;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain 64-bit arithmetic, truncating division; x/0 gives 0.
    function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: latency and result expected after each edge.
    int          m_phase;   // 0 idle, 1 dividing, 2 divide-by-zero, 3 holding result
    int          m_left;
    logic [63:0] m_res;
    logic [63:0] exp_result;
    logic        exp_ready;

    always @(posedge clk) begin
        if (rst) begin
            m_phase    <= 0;
            m_left     <= 0;
            m_res      <= '0;
            exp_ready  <= 1'b0;
            exp_result <= '0;
        end else begin
            case (m_phase)
                0: if (start_i && !annul_i) begin
                       m_res <= ref_div(signed_div_i, opdata1_i, opdata2_i);
                       if (opdata2_i == 32'd0) m_phase <= 2;
                       else begin
                           m_phase <= 1;
                           m_left  <= 32;
                       end
                   end
                1: if (annul_i) m_phase <= 0;
                   else if (m_left == 1) begin
                       m_phase    <= 3;
                       exp_ready  <= 1'b1;
                       exp_result <= m_res;
                   end else m_left <= m_left - 1;
                2: begin
                       m_phase    <= 3;
                       exp_ready  <= 1'b1;
                       exp_result <= m_res;
                   end
                default: if (!start_i) begin
                       m_phase    <= 0;
                       exp_ready  <= 1'b0;
                       exp_result <= '0;
                   end
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_ready", {63'd0, ready_o}, {63'd0, exp_ready});
            check("model_result", result_o, exp_result);
        end
    end

    // One request: latency, result, stability while held, release.
    task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp_lit, input int exp_lat, input int hold,
                           input string name);
        int lat;
        @(negedge clk);
        signed_div_i = sg;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = 1'($urandom_range(0, 1));
        end while (!ready_o && lat < 40);
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_result"}, result_o, exp_lit);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({name, "_hold"}, {ready_o, result_o[62:0]}, {1'b1, exp_lit[62:0]});
        end
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({name, "_release"}, {ready_o, result_o[62:0]}, 64'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        logic        sg;
        logic [63:0] e;
        bit          seen;

        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;

        // Pin the model against hand-computed values.
        check("pin_100_7", ref_div(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
        check("pin_m7_2", ref_div(1'b1, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
        check("pin_7_m2", ref_div(1'b1, 32'd7, 32'hFFFFFFFE), 64'h00000001_FFFFFFFD);
        check("pin_ovf", ref_div(1'b1, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);
        check("pin_div0", ref_div(1'b1, 32'd5, 32'd0), 64'd0);

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {ready_o, result_o[62:0]}, 64'd0);
        @(negedge clk);
        rst    = 1'b0;
        cmp_en = 1'b1;

        run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 32, 2, "udiv_100_7");
        run_div(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 32, 1, "sdiv_m7_2");
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 32, 1, "sdiv_ovf");
        run_div(1'b0, 32'd5, 32'd0, 64'd0, 1, 10, "div_by_zero");

        // Annul at iteration 10, then a fresh request right behind it.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        check("annul_ready", {63'd0, ready_o}, 64'd0);
        run_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 32, 1, "after_annul");

        // Reset at iteration 20.
        @(negedge clk);
        opdata1_i = 32'hFFFFFFFF;
        opdata2_i = 32'h10;
        start_i   = 1'b1;
        @(posedge clk);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            seen |= ready_o;
        end
        check("early_ready", {63'd0, seen}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_reset", {ready_o, result_o[62:0]}, 64'd0);
        rst     = 1'b0;
        start_i = 1'b0;
        run_div(1'b0, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF, 32, 1, "udiv_ffff_10");

        // Randomized requests including corner operands.
        for (int n = 0; n < 30; n++) begin
            sg = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'd1;
                2:       b = 32'hFFFFFFFF;
                3:       b = $urandom_range(1, 255);
                default: b = $urandom;
            endcase
            a = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
            e = ref_div(sg, a, b);
            run_div(sg, a, b, e, (b == 32'd0) ? 1 : 32, $urandom_range(0, 3), "rand_div");
        end

        // Free-running random traffic, checked by the model only.
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            rst          = ($urandom_range(0, 399) == 0);
            start_i      = ($urandom_range(0, 9) != 0);
            annul_i      = ($urandom_range(0, 49) == 0);
            signed_div_i = 1'($urandom_range(0, 1));
            opdata1_i    = $urandom;
            opdata2_i    = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom;
        end
        @(negedge clk);
        rst     = 1'b0;
        start_i = 1'b0;
        annul_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        cmp_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
